// File: rtl/debug_stream_pkg.sv
// Shared types and constants for the multi-channel debug stream capture block.
package debug_stream_pkg;

    // Capture controller states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAITING,
        ST_STREAMING,
        ST_DRAINING,
        ST_DONE
    } state_e;

    localparam int PACKET_COUNT_WIDTH = 16;

    // Width of a channel select for n channels; a single channel still gets one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/debug_stream_mux.sv
// Registered CHANNELS:1 selector of {valid, sop, eop, data}. Adds one pipeline stage.
module debug_stream_mux
    import debug_stream_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int DATA_WIDTH = 14
) (
    input  logic                           ipClk,
    input  logic                           Reset,
    input  logic [CHANNELS-1:0]            valid_i,
    input  logic [CHANNELS-1:0]            sop_i,
    input  logic [CHANNELS-1:0]            eop_i,
    input  logic [CHANNELS*DATA_WIDTH-1:0] data_i,
    input  logic [sel_width(CHANNELS)-1:0] sel_i,
    output logic                           valid_o,
    output logic                           sop_o,
    output logic                           eop_o,
    output logic [DATA_WIDTH-1:0]          data_o
);

    logic                  valid_q;
    logic                  sop_q;
    logic                  eop_q;
    logic [DATA_WIDTH-1:0] data_q;

    // Register the selected channel; an out-of-range select yields no valid sample.
    always_ff @(posedge ipClk) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples
        // pre-edge values regardless of statement order.
        if (Reset) begin
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            data_q  <= '0;
        end else if (int'(sel_i) < CHANNELS) begin
            valid_q <= valid_i[sel_i];
            sop_q   <= sop_i[sel_i];
            eop_q   <= eop_i[sel_i];
            data_q  <= data_i[sel_i*DATA_WIDTH +: DATA_WIDTH];
        end else begin
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            data_q  <= '0;
        end
    end

    assign valid_o = valid_q;
    assign sop_o   = sop_q;
    assign eop_o   = eop_q;
    assign data_o  = data_q;

endmodule

// File: rtl/debug_stream_capture.sv
// Multi-channel packet capture into a live buffer with decimation, truncation and
// per-packet commit of write pointer, packet count and truncation flag.
module debug_stream_capture
    import debug_stream_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int DATA_WIDTH  = 14,
    parameter int WORD_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 13,
    parameter int DECIM_WIDTH = 8
) (
    input  logic                            ipClk,
    input  logic                            Reset,
    input  logic [CHANNELS-1:0]             ipValid,
    input  logic [CHANNELS-1:0]             ipSoP,
    input  logic [CHANNELS-1:0]             ipEoP,
    input  logic [CHANNELS*DATA_WIDTH-1:0]  ipData,
    input  logic [sel_width(CHANNELS)-1:0]  ipChannel,
    input  logic                            ipEnable,
    input  logic                            ipSingle,
    input  logic [DECIM_WIDTH-1:0]          ipDecimate,
    input  logic [ADDR_WIDTH-1:0]           ipMaxLength,
    output logic [ADDR_WIDTH-1:0]           opAddress,
    output logic [WORD_WIDTH-1:0]           opWriteData,
    output logic                            opWrite,
    output logic [ADDR_WIDTH-1:0]           opWrAddress,
    output logic [PACKET_COUNT_WIDTH-1:0]   opPacketCount,
    output logic                            opTruncated,
    output logic                            opBusy
);

    localparam int SEL_W = sel_width(CHANNELS);
    localparam int PAD_W = WORD_WIDTH - DATA_WIDTH;

    // Selected stream after the mux stage.
    logic                  st_valid;
    logic                  st_sop;
    logic                  st_eop;
    logic [DATA_WIDTH-1:0] st_data;

    // Control inputs delayed to line up with the mux stage.
    logic [SEL_W-1:0]       st_chan_q;
    logic                   st_single_q;
    logic [DECIM_WIDTH-1:0] st_decim_q;
    logic [ADDR_WIDTH-1:0]  st_maxlen_q;
    logic                   st_enable_q;

    // Per-packet latched controls.
    state_e                 state_q;
    logic [SEL_W-1:0]       sel_q;
    logic                   single_q;
    logic [DECIM_WIDTH-1:0] decim_q;
    logic [ADDR_WIDTH-1:0]  maxlen_q;

    // Datapath state.
    logic [DECIM_WIDTH-1:0]        phase_q;
    logic [ADDR_WIDTH-1:0]         count_q;
    logic [ADDR_WIDTH-1:0]         next_addr_q;
    logic [ADDR_WIDTH-1:0]         address_q;
    logic [WORD_WIDTH-1:0]         wdata_q;
    logic                          write_q;
    logic [ADDR_WIDTH-1:0]         wr_address_q;
    logic [PACKET_COUNT_WIDTH-1:0] pkt_count_q;
    logic                          truncated_q;
    logic                          busy_q;

    // Combinational helpers.
    logic [SEL_W-1:0]       mux_sel;
    logic [WORD_WIDTH-1:0]  word_d;
    logic [ADDR_WIDTH-1:0]  addr_inc_d;
    logic [ADDR_WIDTH-1:0]  count_inc_d;
    logic [DECIM_WIDTH-1:0] phase_d;
    logic [DECIM_WIDTH-1:0] sop_phase_d;

    debug_stream_mux #(
        .CHANNELS   (CHANNELS),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mux (
        .ipClk   (ipClk),
        .Reset   (Reset),
        .valid_i (ipValid),
        .sop_i   (ipSoP),
        .eop_i   (ipEoP),
        .data_i  (ipData),
        .sel_i   (mux_sel),
        .valid_o (st_valid),
        .sop_o   (st_sop),
        .eop_o   (st_eop),
        .data_o  (st_data)
    );

    // Delay the control inputs by one cycle so they are seen together with their sample.
    always_ff @(posedge ipClk) begin
        if (Reset) begin
            st_chan_q   <= '0;
            st_single_q <= 1'b0;
            st_decim_q  <= '0;
            st_maxlen_q <= '0;
            st_enable_q <= 1'b0;
        end else begin
            st_chan_q   <= ipChannel;
            st_single_q <= ipSingle;
            st_decim_q  <= ipDecimate;
            st_maxlen_q <= ipMaxLength;
            st_enable_q <= ipEnable;
        end
    end

    // Steer the mux: live ipChannel between packets, the packet's channel while one is open.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        mux_sel = ipChannel;
        case (state_q)
            ST_WAITING: begin
                if (st_enable_q && st_valid && st_sop && !st_eop) mux_sel = st_chan_q;
            end
            ST_STREAMING, ST_DRAINING: begin
                if (!(st_valid && st_eop)) mux_sel = sel_q;
            end
            default: ;
        endcase
    end

    // Word formatting, address/count increments and decimation phase stepping.
    always_comb begin
        word_d      = WORD_WIDTH'(st_data) << PAD_W;
        addr_inc_d  = next_addr_q + 1'b1;
        count_inc_d = count_q + 1'b1;
        phase_d     = (phase_q == decim_q) ? '0 : phase_q + 1'b1;
        sop_phase_d = (st_decim_q == '0) ? '0 : DECIM_WIDTH'(1);
    end

    // Capture FSM with registered write port and commit outputs.
    always_ff @(posedge ipClk) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            sel_q        <= '0;
            single_q     <= 1'b0;
            decim_q      <= '0;
            maxlen_q     <= '0;
            phase_q      <= '0;
            count_q      <= '0;
            next_addr_q  <= '0;
            address_q    <= '0;
            wdata_q      <= '0;
            write_q      <= 1'b0;
            wr_address_q <= '0;
            pkt_count_q  <= '0;
            truncated_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            write_q     <= 1'b0;
            truncated_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (st_enable_q) state_q <= ST_WAITING;
                end
                ST_WAITING: begin
                    if (!st_enable_q) begin
                        state_q <= ST_IDLE;
                    end else if (st_valid && st_sop) begin
                        sel_q       <= st_chan_q;
                        single_q    <= st_single_q;
                        decim_q     <= st_decim_q;
                        maxlen_q    <= st_maxlen_q;
                        write_q     <= 1'b1;
                        address_q   <= next_addr_q;
                        wdata_q     <= word_d;
                        next_addr_q <= addr_inc_d;
                        phase_q     <= sop_phase_d;
                        count_q     <= ADDR_WIDTH'(1);
                        if (st_eop) begin
                            wr_address_q <= addr_inc_d;
                            pkt_count_q  <= pkt_count_q + 1'b1;
                            state_q      <= st_single_q ? ST_DONE : ST_WAITING;
                        end else if (st_maxlen_q == ADDR_WIDTH'(1)) begin
                            state_q <= ST_DRAINING;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= ST_STREAMING;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ST_STREAMING: begin
                    if (st_valid) begin
                        phase_q <= phase_d;
                        if (phase_q == '0) begin
                            write_q     <= 1'b1;
                            address_q   <= next_addr_q;
                            wdata_q     <= word_d;
                            next_addr_q <= addr_inc_d;
                            count_q     <= count_inc_d;
                        end
                        if (st_eop) begin
                            wr_address_q <= (phase_q == '0) ? addr_inc_d : next_addr_q;
                            pkt_count_q  <= pkt_count_q + 1'b1;
                            state_q      <= single_q ? ST_DONE : ST_WAITING;
                            busy_q       <= 1'b0;
                        end else if (phase_q == '0 && maxlen_q != '0 && count_inc_d == maxlen_q) begin
                            state_q <= ST_DRAINING;
                        end
                    end
                end
                ST_DRAINING: begin
                    if (st_valid && st_eop) begin
                        wr_address_q <= next_addr_q;
                        pkt_count_q  <= pkt_count_q + 1'b1;
                        truncated_q  <= 1'b1;
                        state_q      <= single_q ? ST_DONE : ST_WAITING;
                        busy_q       <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (!st_enable_q) state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign opAddress     = address_q;
    assign opWriteData   = wdata_q;
    assign opWrite       = write_q;
    assign opWrAddress   = wr_address_q;
    assign opPacketCount = pkt_count_q;
    assign opTruncated   = truncated_q;
    assign opBusy        = busy_q;

endmodule

// File: tb/tb_debug_stream_capture.sv
// Self-checking bench for debug_stream_capture: directed scenarios plus randomized
// noisy packets, compared against a packet-level reference model.
module tb_debug_stream_capture;

    localparam int CH  = 4;
    localparam int DW  = 14;
    localparam int WW  = 16;
    localparam int AW  = 13;
    localparam int DCW = 8;
    localparam int DTW = CH * DW;

    logic            ipClk = 1'b0;
    logic            Reset;
    logic [CH-1:0]   ipValid, ipSoP, ipEoP;
    logic [DTW-1:0]  ipData;
    logic [1:0]      ipChannel;
    logic            ipEnable, ipSingle;
    logic [DCW-1:0]  ipDecimate;
    logic [AW-1:0]   ipMaxLength;
    logic [AW-1:0]   opAddress;
    logic [WW-1:0]   opWriteData;
    logic            opWrite;
    logic [AW-1:0]   opWrAddress;
    logic [15:0]     opPacketCount;
    logic            opTruncated;
    logic            opBusy;

    debug_stream_capture #(
        .CHANNELS(CH), .DATA_WIDTH(DW), .WORD_WIDTH(WW), .ADDR_WIDTH(AW), .DECIM_WIDTH(DCW)
    ) dut (
        .ipClk(ipClk), .Reset(Reset), .ipValid(ipValid), .ipSoP(ipSoP), .ipEoP(ipEoP),
        .ipData(ipData), .ipChannel(ipChannel), .ipEnable(ipEnable), .ipSingle(ipSingle),
        .ipDecimate(ipDecimate), .ipMaxLength(ipMaxLength), .opAddress(opAddress),
        .opWriteData(opWriteData), .opWrite(opWrite), .opWrAddress(opWrAddress),
        .opPacketCount(opPacketCount), .opTruncated(opTruncated), .opBusy(opBusy)
    );

    always #5 ipClk = ~ipClk;

    typedef struct {
        logic [AW-1:0] a;
        logic [WW-1:0] d;
    } wr_t;

    int total = 0;
    int bad   = 0;

    // Observed activity, collected on the falling edge.
    wr_t         obs_q[$];
    int          commits = 0;
    int          truncs = 0;
    int          commit_with_wr = 0;
    int          busy_seen = 0;
    logic [15:0] prev_cnt = '0;

    // Reference model state.
    wr_t exp_q[$];
    int  model_addr = 0;
    int  model_cnt = 0;
    int  exp_commits = 0;
    int  exp_truncs = 0;
    int  last_addr = -1;

    always @(negedge ipClk) begin
        if (!Reset) begin
            if (opWrite) obs_q.push_back('{opAddress, opWriteData});
            if (opPacketCount != prev_cnt) begin
                commits++;
                commit_with_wr = int'(opWrite);
            end
            if (opTruncated) truncs++;
            if (opBusy) busy_seen = 1;
        end
        prev_cnt = opPacketCount;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge ipClk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        ipValid = '0;
        ipSoP   = '0;
        ipEoP   = '0;
        step(n);
    endtask

    task automatic noise();
        ipValid = CH'($urandom);
        ipSoP   = CH'($urandom);
        ipEoP   = CH'($urandom);
        ipData  = DTW'({$urandom, $urandom});
    endtask

    // Drive one packet on channel ch and, if it should be captured, extend the model.
    task automatic send_packet(input int ch, input int len, input int dec, input int mlen,
                               input bit single, input bit capture, input bit noisy);
        logic [DW-1:0] samples[$];
        int kept_before_eop;
        int n_keep;
        bit trunc;
        for (int i = 0; i < len; i++) begin
            if (noisy && i > 0) begin
                repeat ($urandom_range(0, 1)) begin
                    noise();
                    ipValid[ch] = 1'b0;
                    ipChannel   = 2'($urandom);
                    step(1);
                end
            end
            if (noisy) noise();
            else begin
                ipValid = '0;
                ipSoP   = '0;
                ipEoP   = '0;
                ipData  = '0;
            end
            samples.push_back(DW'($urandom));
            ipValid[ch]           = 1'b1;
            ipSoP[ch]             = (i == 0) || (noisy && i < len - 1 && $urandom_range(0, 5) == 0);
            ipEoP[ch]             = (i == len - 1);
            ipData[ch*DW +: DW]   = samples[i];
            if (i == 0) begin
                ipChannel   = 2'(ch);
                ipDecimate  = DCW'(dec);
                ipMaxLength = AW'(mlen);
                ipSingle    = single;
            end else if (noisy) begin
                ipChannel   = 2'($urandom);
                ipDecimate  = DCW'($urandom);
                ipMaxLength = AW'($urandom);
                ipSingle    = 1'($urandom);
            end
            step(1);
        end
        ipValid = '0;
        ipSoP   = '0;
        ipEoP   = '0;
        if (capture) begin
            kept_before_eop = 0;
            for (int i = 0; i < len - 1; i++)
                if (i % (dec + 1) == 0) kept_before_eop++;
            trunc  = (mlen != 0) && (kept_before_eop >= mlen);
            n_keep = 0;
            for (int i = 0; i < len; i++) begin
                if (i % (dec + 1) == 0 && !(trunc && n_keep == mlen)) begin
                    exp_q.push_back('{AW'(model_addr), WW'(samples[i]) << (WW - DW)});
                    last_addr  = model_addr;
                    model_addr = (model_addr + 1) % (1 << AW);
                    n_keep++;
                end
            end
            model_cnt++;
            exp_commits++;
            if (trunc) exp_truncs++;
        end
    endtask

    // Flush the pipeline and compare everything observed since the last check.
    task automatic check_batch(input string tag);
        wr_t o, e;
        idle(6);
        chk({tag, "_nwrites"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            chk({tag, "_addr"}, o.a, e.a);
            chk({tag, "_data"}, o.d, e.d);
        end
        chk({tag, "_commits"}, commits, exp_commits);
        chk({tag, "_truncs"}, truncs, exp_truncs);
        chk({tag, "_wraddr"}, opWrAddress, model_addr);
        chk({tag, "_pktcnt"}, opPacketCount, model_cnt);
        chk({tag, "_busy_low"}, opBusy, 0);
        chk({tag, "_wrlow"}, opWrite, 0);
        if (last_addr >= 0) chk({tag, "_addr_hold"}, opAddress, last_addr);
        obs_q.delete();
        exp_q.delete();
        commits     = 0;
        truncs      = 0;
        exp_commits = 0;
        exp_truncs  = 0;
    endtask

    task automatic reenable(input bit single);
        ipEnable = 1'b0;
        idle(5);
        ipSingle = single;
        ipEnable = 1'b1;
        idle(5);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_address"}, opAddress, 0);
        chk({tag, "_wdata"}, opWriteData, 0);
        chk({tag, "_write"}, opWrite, 0);
        chk({tag, "_wraddr"}, opWrAddress, 0);
        chk({tag, "_pktcnt"}, opPacketCount, 0);
        chk({tag, "_trunc"}, opTruncated, 0);
        chk({tag, "_busy"}, opBusy, 0);
    endtask

    initial begin
        int pad;
        Reset       = 1'b1;
        ipValid     = '0;
        ipSoP       = '0;
        ipEoP       = '0;
        ipData      = '0;
        ipChannel   = '0;
        ipEnable    = 1'b0;
        ipSingle    = 1'b0;
        ipDecimate  = '0;
        ipMaxLength = '0;
        repeat (3) @(posedge ipClk);
        @(negedge ipClk);
        check_reset_outputs("rst");
        @(posedge ipClk);
        #1;
        Reset    = 1'b0;
        ipEnable = 1'b1;
        idle(5);

        // Plain 8-sample packet on channel 2.
        busy_seen = 0;
        send_packet(2, 8, 0, 0, 0, 1, 0);
        check_batch("basic");
        chk("basic_commit_with_write", commit_with_wr, 1);
        chk("basic_busy_seen", busy_seen, 1);

        // Decimation keeps samples 0, 3, 6.
        send_packet(1, 9, 2, 0, 0, 1, 0);
        check_batch("decim");

        // Truncation to four words.
        send_packet(3, 10, 0, 4, 0, 1, 0);
        check_batch("trunc");

        // Single-shot: the second back-to-back packet is ignored.
        send_packet(0, 5, 0, 0, 1, 1, 0);
        send_packet(0, 5, 0, 0, 1, 0, 0);
        check_batch("single");
        reenable(1'b1);
        send_packet(2, 4, 0, 0, 1, 1, 0);
        check_batch("single_rearm");
        reenable(1'b0);

        // One-word packet: SoP and EoP together.
        send_packet(1, 1, 0, 0, 0, 1, 0);
        check_batch("sop_eop");

        // Randomized noisy packets: unselected traffic, mid-packet control changes.
        for (int k = 0; k < 8; k++) begin
            send_packet($urandom_range(0, 3), $urandom_range(1, 20), $urandom_range(0, 3),
                        $urandom_range(0, 8), 0, 1, 1);
            idle($urandom_range(0, 2));
        end
        check_batch("random");

        // Address wrap: pad up to 8190, then a 4-sample packet.
        pad = (8190 - model_addr) % (1 << AW);
        if (pad < 0) pad += (1 << AW);
        if (pad > 0) begin
            send_packet(0, pad, 0, 0, 0, 1, 0);
            check_batch("pad");
        end
        send_packet(2, 4, 0, 0, 0, 1, 0);
        chk("wrap_first_addr", exp_q[0].a, 8190);
        check_batch("wrap");
        chk("wrap_wraddr_is_2", opWrAddress, 2);

        // Reset in the middle of a packet.
        ipChannel = 2'd0;
        for (int i = 0; i < 4; i++) begin
            ipValid = 4'b0001;
            ipSoP   = (i == 0) ? 4'b0001 : 4'b0000;
            ipEoP   = '0;
            ipData  = DTW'($urandom);
            step(1);
        end
        Reset   = 1'b1;
        ipValid = '0;
        ipSoP   = '0;
        @(posedge ipClk);
        @(negedge ipClk);
        check_reset_outputs("midrst");
        @(posedge ipClk);
        #1;
        Reset = 1'b0;
        obs_q.delete();
        exp_q.delete();
        commits     = 0;
        truncs      = 0;
        model_addr  = 0;
        model_cnt   = 0;
        last_addr   = -1;
        idle(5);
        send_packet(3, 3, 0, 0, 0, 1, 0);
        check_batch("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
